// File: rtl/me_result_display.sv
// Captures a finished motion search, converts the raster mvec index into signed
// (dx,dy) decimal digits with a sequential divider/BCD stage, and drives HEX5..HEX0.
module me_result_display #(
    parameter  int unsigned TB_LENGTH    = 16,
    parameter  int unsigned SW_LENGTH    = 64,
    parameter  int unsigned PE_OUT_WIDTH = 8,
    localparam int unsigned SAD_WIDTH    = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH,
    localparam int unsigned RANGE        = SW_LENGTH - TB_LENGTH + 1,
    localparam int unsigned CNT_WIDTH    = $clog2(RANGE * RANGE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ack,
    input  logic [SAD_WIDTH-1:0] min_sad,
    input  logic [CNT_WIDTH-1:0] min_mvec,
    input  logic                 sel,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1,
    output logic [6:0]           hex2,
    output logic [6:0]           hex3,
    output logic [6:0]           hex4,
    output logic [6:0]           hex5,
    output logic                 busy,
    output logic                 valid
);

    localparam int unsigned C        = (RANGE - 1) / 2;
    localparam int unsigned RANGE_SQ = RANGE * RANGE;
    localparam int unsigned MAG_W    = 7;
    localparam int unsigned TENS_W   = 4;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_SIGN,
        S_BCD,
        S_UPD
    } state_t;

    state_t                r_state;
    logic                  r_ack_d;
    logic                  r_busy;
    logic                  r_valid;
    logic [SAD_WIDTH-1:0]  r_sad;
    logic [CNT_WIDTH-1:0]  r_rem;
    logic [CNT_WIDTH-1:0]  r_qy;
    logic                  r_err;
    logic                  r_neg_x;
    logic                  r_neg_y;
    logic [MAG_W-1:0]      r_mag_x;
    logic [MAG_W-1:0]      r_mag_y;
    logic [TENS_W-1:0]     r_tens_x;
    logic [TENS_W-1:0]     r_tens_y;

    // Display store: only rewritten when a decode completes
    logic                  r_st_err;
    logic                  r_st_neg_x;
    logic                  r_st_neg_y;
    logic [3:0]            r_st_tens_x;
    logic [3:0]            r_st_tens_y;
    logic [3:0]            r_st_ones_x;
    logic [3:0]            r_st_ones_y;

    logic [6:0]            r_hex [6];

    logic                  w_rise;
    logic [15:0]           w_sad16;

    assign w_rise  = ack & ~r_ack_d;
    assign w_sad16 = 16'(r_sad);

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Capture / divide / sign / BCD / update sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ack_d     <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_sad       <= '0;
            r_rem       <= '0;
            r_qy        <= '0;
            r_err       <= 1'b0;
            r_neg_x     <= 1'b0;
            r_neg_y     <= 1'b0;
            r_mag_x     <= '0;
            r_mag_y     <= '0;
            r_tens_x    <= '0;
            r_tens_y    <= '0;
            r_st_err    <= 1'b0;
            r_st_neg_x  <= 1'b0;
            r_st_neg_y  <= 1'b0;
            r_st_tens_x <= '0;
            r_st_tens_y <= '0;
            r_st_ones_x <= '0;
            r_st_ones_y <= '0;
        end else begin
            r_ack_d <= ack;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_sad   <= min_sad;
                        r_rem   <= min_mvec;
                        r_qy    <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (32'(r_rem) >= RANGE_SQ) begin
                        r_err   <= 1'b1;
                        r_state <= S_UPD;
                    end else if (r_rem >= CNT_WIDTH'(RANGE)) begin
                        r_rem <= r_rem - CNT_WIDTH'(RANGE);
                        r_qy  <= r_qy + CNT_WIDTH'(1);
                    end else begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    // Offsets from window centre as sign + magnitude
                    r_neg_x  <= (r_rem < CNT_WIDTH'(C));
                    r_neg_y  <= (r_qy < CNT_WIDTH'(C));
                    r_mag_x  <= (r_rem < CNT_WIDTH'(C)) ? MAG_W'(CNT_WIDTH'(C) - r_rem)
                                                        : MAG_W'(r_rem - CNT_WIDTH'(C));
                    r_mag_y  <= (r_qy < CNT_WIDTH'(C)) ? MAG_W'(CNT_WIDTH'(C) - r_qy)
                                                       : MAG_W'(r_qy - CNT_WIDTH'(C));
                    r_tens_x <= '0;
                    r_tens_y <= '0;
                    r_state  <= S_BCD;
                end
                S_BCD: begin
                    if (r_mag_x >= MAG_W'(10)) begin
                        r_mag_x  <= r_mag_x - MAG_W'(10);
                        r_tens_x <= r_tens_x + TENS_W'(1);
                    end
                    if (r_mag_y >= MAG_W'(10)) begin
                        r_mag_y  <= r_mag_y - MAG_W'(10);
                        r_tens_y <= r_tens_y + TENS_W'(1);
                    end
                    if ((r_mag_x < MAG_W'(10)) && (r_mag_y < MAG_W'(10))) begin
                        r_state <= S_UPD;
                    end
                end
                S_UPD: begin
                    r_st_err    <= r_err;
                    r_st_neg_x  <= r_neg_x;
                    r_st_neg_y  <= r_neg_y;
                    r_st_tens_x <= r_tens_x;
                    r_st_tens_y <= r_tens_y;
                    r_st_ones_x <= r_mag_x[3:0];
                    r_st_ones_y <= r_mag_y[3:0];
                    r_valid     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Segment registers refresh every cycle from the store and sel
    always_ff @(posedge clk) begin
        if (rst || !r_valid) begin
            for (int i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
        end else if (sel) begin
            r_hex[5] <= SEG_BLANK;
            r_hex[4] <= SEG_BLANK;
            r_hex[3] <= f_seg(w_sad16[15:12]);
            r_hex[2] <= f_seg(w_sad16[11:8]);
            r_hex[1] <= f_seg(w_sad16[7:4]);
            r_hex[0] <= f_seg(w_sad16[3:0]);
        end else if (r_st_err) begin
            for (int i = 0; i < 6; i++) r_hex[i] <= SEG_DASH;
        end else begin
            r_hex[5] <= r_st_neg_y ? SEG_DASH : SEG_BLANK;
            r_hex[4] <= f_seg(r_st_tens_y);
            r_hex[3] <= f_seg(r_st_ones_y);
            r_hex[2] <= r_st_neg_x ? SEG_DASH : SEG_BLANK;
            r_hex[1] <= f_seg(r_st_tens_x);
            r_hex[0] <= f_seg(r_st_ones_x);
        end
    end

    assign hex0  = r_hex[0];
    assign hex1  = r_hex[1];
    assign hex2  = r_hex[2];
    assign hex3  = r_hex[3];
    assign hex4  = r_hex[4];
    assign hex5  = r_hex[5];
    assign busy  = r_busy;
    assign valid = r_valid;

endmodule

// File: tb/tb_me_result_display.sv
// Directed bench for me_result_display: arithmetic reference model compared every
// cycle, plus hand-computed latency and segment expectations.
module tb_me_result_display;

    localparam int RANGE = 49;
    localparam int C     = 24;
    localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
    localparam logic [41:0] ALL_DASH  = {6{7'h3F}};

    logic        clk = 1'b0;
    logic        rst;
    logic        ack;
    logic [15:0] min_sad;
    logic [11:0] min_mvec;
    logic        sel;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        busy, valid;

    int n_vec = 0;
    int n_err = 0;

    me_result_display dut (
        .clk      (clk),
        .rst      (rst),
        .ack      (ack),
        .min_sad  (min_sad),
        .min_mvec (min_mvec),
        .sel      (sel),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .busy     (busy),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] hexes();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    // Expected segment pattern from the result the display should be holding
    function automatic logic [41:0] f_disp(bit v, bit e, bit s, logic [15:0] sad, int dx, int dy);
        int ax;
        int ay;
        if (!v) return ALL_BLANK;
        if (s) return {7'h7F, 7'h7F, GLY[sad[15:12]], GLY[sad[11:8]], GLY[sad[7:4]], GLY[sad[3:0]]};
        if (e) return ALL_DASH;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        return {(dy < 0) ? 7'h3F : 7'h7F, GLY[ay / 10], GLY[ay % 10],
                (dx < 0) ? 7'h3F : 7'h7F, GLY[ax / 10], GLY[ax % 10]};
    endfunction

    // Reference model: result computed by division at capture, released after its latency
    bit          m_live = 1'b0;
    bit          m_ack_d, m_busy, m_valid, m_err, p_err;
    int          m_cnt, m_dx, m_dy, p_dx, p_dy;
    logic [15:0] m_sad;
    logic [41:0] m_hex;

    always @(posedge clk) begin
        int mv;
        int tx;
        int ty;
        if (rst) begin
            m_ack_d = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            m_cnt = 0; m_dx = 0; m_dy = 0; m_sad = '0; m_hex = ALL_BLANK;
            m_live = 1'b1;
        end else if (m_live) begin
            m_hex = f_disp(m_valid, m_err, sel, m_sad, m_dx, m_dy);
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_valid = 1'b1;
                    m_err = p_err; m_dx = p_dx; m_dy = p_dy;
                end
            end else if (ack && !m_ack_d) begin
                m_busy = 1'b1; m_valid = 1'b0; m_sad = min_sad;
                mv = int'(min_mvec);
                if (mv >= RANGE * RANGE) begin
                    p_err = 1'b1; m_cnt = 2;
                end else begin
                    p_err = 1'b0;
                    p_dx = mv % RANGE - C;
                    p_dy = mv / RANGE - C;
                    tx = ((p_dx < 0) ? -p_dx : p_dx) / 10;
                    ty = ((p_dy < 0) ? -p_dy : p_dy) / 10;
                    m_cnt = mv / RANGE + ((tx > ty) ? tx : ty) + 4;
                end
            end
            m_ack_d = ack;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            n_vec++;
            if ({busy, valid, hexes()} !== {m_busy, m_valid, m_hex}) begin
                n_err++;
                $display("FAIL model_cmp t=%0t busy/valid/hex got=%b%b_%h exp=%b%b_%h",
                         $time, busy, valid, hexes(), m_busy, m_valid, m_hex);
            end
        end
    end

    task automatic lit_chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Launch one result; edge 0 is the posedge that samples the ack rise
    task automatic run(input logic [11:0] mvec, input logic [15:0] sad, input int exp_lat,
                       input int drop_at, input int rise_at, input int rst_at);
        int n;
        bit done;
        @(negedge clk);
        min_mvec = mvec; min_sad = sad; ack = 1'b1;
        @(posedge clk);
        n = 0; done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (rst_at > 0 && n == rst_at) begin
                lit_chk("midrst_busy_valid", 64'({busy, valid}), 64'(2'b00));
                lit_chk("midrst_hex", 64'(hexes()), 64'(ALL_BLANK));
                rst = 1'b0;
                done = 1'b1;
            end else if (valid) begin
                lit_chk($sformatf("latency_%0d", mvec), 64'(n), 64'(exp_lat));
                done = 1'b1;
            end else begin
                if (n + 1 == rst_at) begin rst = 1'b1; ack = 1'b0; end
                if (n + 1 == drop_at) ack = 1'b0;
                if (n + 1 == rise_at) ack = 1'b1;
                @(posedge clk);
                n++;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout mvec=%0d edges=%0d", mvec, n);
        end
    endtask

    task automatic step_chk(input string name, input logic [41:0] exp);
        @(negedge clk);
        lit_chk(name, 64'(hexes()), 64'(exp));
    endtask

    task automatic release_ack();
        repeat (2) @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; sel = 1'b0; min_sad = '0; min_mvec = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit_chk("reset_busy_valid", 64'({busy, valid}), 64'(2'b00));
        lit_chk("reset_hex", 64'(hexes()), 64'(ALL_BLANK));
        rst = 1'b0; sel = 1'b1;
        step_chk("blank_sel1", ALL_BLANK);
        sel = 1'b0;
        step_chk("blank_sel0", ALL_BLANK);

        // Centre of window: "00 00"
        run(12'd1200, 16'hABCD, 28, 0, 0, 0);
        step_chk("hex_1200", {7'h7F, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h40});
        sel = 1'b1;
        step_chk("hex_sad_abcd", {7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21});
        sel = 1'b0;
        step_chk("hex_restore", {7'h7F, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h40});
        release_ack();

        run(12'd0, 16'h0001, 6, 0, 0, 0);
        step_chk("hex_0", {7'h3F, 7'h24, 7'h19, 7'h3F, 7'h24, 7'h19});
        release_ack();

        run(12'd2400, 16'h0002, 54, 0, 0, 0);
        step_chk("hex_2400", {7'h7F, 7'h24, 7'h19, 7'h7F, 7'h24, 7'h19});
        release_ack();

        run(12'd1176, 16'h0003, 30, 0, 0, 0);
        step_chk("hex_1176", {7'h7F, 7'h40, 7'h40, 7'h3F, 7'h24, 7'h19});
        release_ack();

        run(12'd1224, 16'h0004, 30, 0, 0, 0);
        step_chk("hex_1224", {7'h7F, 7'h40, 7'h40, 7'h7F, 7'h24, 7'h19});
        release_ack();

        run(12'd276, 16'h5678, 10, 0, 0, 0);
        step_chk("hex_276", {7'h3F, 7'h79, 7'h10, 7'h7F, 7'h40, 7'h78});
        release_ack();

        run(12'd2027, 16'h9EF0, 46, 0, 0, 0);
        step_chk("hex_2027", {7'h7F, 7'h79, 7'h78, 7'h3F, 7'h40, 7'h02});
        sel = 1'b1;
        step_chk("hex_sad_9ef0", {7'h7F, 7'h7F, 7'h10, 7'h06, 7'h0E, 7'h40});
        sel = 1'b0;
        release_ack();

        // Out-of-range index
        run(12'd4000, 16'h1234, 2, 0, 0, 0);
        step_chk("hex_err", ALL_DASH);
        sel = 1'b1;
        step_chk("hex_err_sad", {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
        sel = 1'b0;
        release_ack();

        // Second rise while dividing is ignored
        run(12'd2400, 16'h0005, 54, 5, 8, 0);
        step_chk("hex_ignored_rise", {7'h7F, 7'h24, 7'h19, 7'h7F, 7'h24, 7'h19});
        release_ack();

        // Reset during divide, then a clean result afterwards
        run(12'd2400, 16'h0006, 0, 0, 0, 10);
        repeat (2) @(negedge clk);
        run(12'd37, 16'h0007, 6, 0, 0, 0);
        step_chk("hex_37", {7'h3F, 7'h24, 7'h19, 7'h7F, 7'h79, 7'h30});
        release_ack();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
